// File: rtl/student_ss_analog_pkg.sv
// Shared types and constants for the analog student subsystem sequencer.
package student_ss_analog_pkg;
  localparam int NUM_CH        = 4;
  localparam int CH_W          = 2;
  localparam int DEF_MAX_RETRY = 3;
  localparam int RETRY_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_CHECK,
    ST_EMIT,
    ST_DONE
  } state_e;
endpackage

// File: rtl/analog_ch_pick.sv
// Next enabled channel finder: lowest set mask bit when first=1,
// otherwise the lowest set bit strictly above cur; none=1 if there is none.
module analog_ch_pick
  import student_ss_analog_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              first,
  output logic [CH_W-1:0]   nxt,
  output logic              none
);

  // Descending scan so the last qualifying hit is the lowest one.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        nxt  = CH_W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/student_ss_analog_seq.sv
// Analog measurement sequencer: enable, settle, then capture each enabled
// status word once two consecutive reads agree, streaming results out.
module student_ss_analog_seq
  import student_ss_analog_pkg::*;
#(
  parameter int SETTLE_W  = 16,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic                abort_in,
  input  logic [SETTLE_W-1:0] settle_cycles_in,
  input  logic [NUM_CH-1:0]   ch_mask_in,
  input  logic [31:0]         status_0_in,
  input  logic [31:0]         status_1_in,
  input  logic [31:0]         status_2_in,
  input  logic [31:0]         status_3_in,
  output logic                ana_en_out,
  output logic [CH_W-1:0]     ana_sel_out,
  output logic                res_valid_out,
  input  logic                res_ready_in,
  output logic [31:0]         res_data_out,
  output logic [CH_W-1:0]     res_ch_out,
  output logic                res_err_out,
  output logic                busy_out,
  output logic                done_out
);

  state_e                    state_q, state_d;
  logic [SETTLE_W-1:0]       settle_q, settle_d;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [CH_W-1:0]           ch_d;
  logic [31:0]               shadow_q, shadow_d;
  logic [31:0]               data_d;
  logic [CH_W-1:0]           rch_d;
  logic                      err_d;
  logic [NUM_CH-1:0][31:0]   st;
  logic [31:0]               cur_status;
  logic [NUM_CH-1:0]         pick_mask;
  logic                      pick_first, pick_none;
  logic [CH_W-1:0]           pick_nxt;

  assign st         = {status_3_in, status_2_in, status_1_in, status_0_in};
  assign cur_status = st[ana_sel_out];

  // In IDLE the mask is not latched yet, so look at the live input.
  assign pick_first = (state_q == ST_IDLE);
  assign pick_mask  = pick_first ? ch_mask_in : mask_q;

  analog_ch_pick u_pick (
    .mask  (pick_mask),
    .cur   (ana_sel_out),
    .first (pick_first),
    .nxt   (pick_nxt),
    .none  (pick_none)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    retry_d  = retry_q;
    mask_d   = mask_q;
    ch_d     = ana_sel_out;
    shadow_d = shadow_q;
    data_d   = res_data_out;
    rch_d    = res_ch_out;
    err_d    = res_err_out;
    if (abort_in) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            mask_d   = ch_mask_in;
            settle_d = settle_cycles_in;
            retry_d  = '0;
            if (pick_none) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SETTLE;
              ch_d    = pick_nxt;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) state_d = ST_SAMPLE;
          else                settle_d = settle_q - 1'b1;
        end
        ST_SAMPLE: begin
          shadow_d = cur_status;
          state_d  = ST_CHECK;
        end
        ST_CHECK: begin
          if (cur_status == shadow_q) begin
            data_d  = shadow_q;
            rch_d   = ana_sel_out;
            err_d   = 1'b0;
            state_d = ST_EMIT;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d  = retry_q + 1'b1;
            shadow_d = cur_status;
          end else begin
            data_d  = cur_status;
            rch_d   = ana_sel_out;
            err_d   = 1'b1;
            state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (res_ready_in) begin
            retry_d = '0;
            if (pick_none) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SAMPLE;
              ch_d    = pick_nxt;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status outputs are registered copies of what the next state implies.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      settle_q      <= '0;
      retry_q       <= '0;
      mask_q        <= '0;
      shadow_q      <= '0;
      ana_sel_out   <= '0;
      res_data_out  <= '0;
      res_ch_out    <= '0;
      res_err_out   <= 1'b0;
      ana_en_out    <= 1'b0;
      res_valid_out <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      retry_q       <= retry_d;
      mask_q        <= mask_d;
      shadow_q      <= shadow_d;
      ana_sel_out   <= ch_d;
      res_data_out  <= data_d;
      res_ch_out    <= rch_d;
      res_err_out   <= err_d;
      ana_en_out    <= (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) ||
                       (state_d == ST_CHECK)  || (state_d == ST_EMIT);
      res_valid_out <= (state_d == ST_EMIT);
      busy_out      <= (state_d != ST_IDLE);
      done_out      <= (state_d == ST_DONE);
    end
  end

endmodule
